if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 35 +++
 rtl/if_stage.sv | 154 +++++++++++++++
 tb/tb_if_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: reset defaults, bubble encoding,
// fetch FSM states and the IF/ID register layout.
package if_stage_pkg;

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST_DEFAULT = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        valid;
    } ifid_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        valid;
    } skid_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding imem fetch FSM, PC register, one-entry skid
// buffer for responses arriving under stall, and the IF/ID pipeline register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        take_branch,
    input  logic [31:0] target_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic        if_id_valid_inst
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  issued_pc_q, issued_pc_d;
    logic         drop_q, drop_d;
    skid_t        skid_q, skid_d;
    ifid_t        ifid_q, ifid_d;

    logic [31:0]  fetch_addr;
    ifid_t        bubble;
    logic         deliver;
    logic [31:0]  deliver_ir;
    logic [31:0]  deliver_pc;

    assign fetch_addr = word_align(pc_q);
    assign bubble     = '{ir: NOP_INST, pc: fetch_addr, valid: 1'b0};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        drop_d      = drop_q;
        skid_d      = skid_q;
        ifid_d      = ifid_q;
        deliver     = 1'b0;
        deliver_ir  = '0;
        deliver_pc  = '0;

        if (take_branch) begin
            // Redirect beats stall and every FSM action.
            pc_d         = word_align(target_pc);
            skid_d.valid = 1'b0;
            ifid_d       = bubble;
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        // Old address was accepted; its response must be swallowed.
                        issued_pc_d = fetch_addr;
                        drop_d      = 1'b1;
                        state_d     = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    state_d = S_REQ;
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        issued_pc_d = fetch_addr;
                        state_d     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (!stall) begin
                            deliver    = 1'b1;
                            deliver_ir = imem_rdata;
                            deliver_pc = issued_pc_q;
                            pc_d       = pc_q + 32'd4;
                            state_d    = S_REQ;
                        end else begin
                            skid_d  = '{ir: imem_rdata, pc: issued_pc_q, valid: 1'b1};
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        deliver      = skid_q.valid;
                        deliver_ir   = skid_q.ir;
                        deliver_pc   = skid_q.pc;
                        skid_d.valid = 1'b0;
                        pc_d         = pc_q + 32'd4;
                        state_d      = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase

            if (deliver) begin
                ifid_d = '{ir: deliver_ir, pc: deliver_pc, valid: 1'b1};
            end else if (!stall) begin
                ifid_d = bubble;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            issued_pc_q <= '0;
            drop_q      <= 1'b0;
            skid_q      <= '0;
            ifid_q      <= '{ir: NOP_INST, pc: 32'h0, valid: 1'b0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            drop_q      <= drop_d;
            skid_q      <= skid_d;
            ifid_q      <= ifid_d;
        end
    end

    assign imem_req         = (state_q == S_REQ);
    assign imem_addr        = fetch_addr;
    assign if_id_IR         = ifid_q.ir;
    assign if_id_PC         = ifid_q.pc;
    assign if_id_valid_inst = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a memory responder feeds a scoreboard of expected
// deliveries in program order; a posedge monitor checks IF/ID against it.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        take_branch = 1'b0;
    logic [31:0] target_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_id_IR;
    logic [31:0] if_id_PC;
    logic        if_id_valid_inst;

    if_stage #(
        .RESET_PC(RST_PC),
        .NOP_INST(NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .take_branch     (take_branch),
        .target_pc       (target_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_id_IR        (if_id_IR),
        .if_id_PC        (if_id_PC),
        .if_id_valid_inst(if_id_valid_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb_q[$];

    // Reference model state
    logic [31:0] exp_fetch;
    bit          outstanding;
    bit          out_dead;
    logic [31:0] out_addr;
    int          lat;
    int p_ready, p_stall, p_branch, p_spur, max_lat;
    bit cyc_stall = 1'b0;
    bit cyc_branch = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic logic [31:0] random_target();
        if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(15));
        return $urandom() & 32'h0000_0FFF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        exp_fetch   = RST_PC;
        outstanding = 1'b0;
        out_dead    = 1'b0;
        lat         = 0;
    endtask

    task automatic set_knobs(input int rdy, input int stl, input int br, input int spur,
                             input int ml);
        p_ready = rdy; p_stall = stl; p_branch = br; p_spur = spur; max_lat = ml;
    endtask

    // Drive inputs for the coming rising edge; called just after a falling edge.
    task automatic step(input bit force_br, input logic [31:0] force_tgt, input bit force_stall);
        bit          br;
        bit          rv;
        logic [31:0] tgt;
        br  = force_br || ($urandom_range(99) < p_branch);
        tgt = force_br ? force_tgt : random_target();
        take_branch = br;
        target_pc   = tgt;
        stall       = force_stall || ($urandom_range(99) < p_stall);
        imem_ready  = ($urandom_range(99) < p_ready);
        imem_rdata  = $urandom();
        rv = 1'b0;
        if (outstanding) begin
            check("req_low_while_waiting", {31'b0, imem_req}, 32'h0);
            if (lat == 0) begin
                rv          = 1'b1;
                imem_rdata  = mem_word(out_addr);
                if (!out_dead && !br) sb_q.push_back('{pc: out_addr, ir: mem_word(out_addr)});
                outstanding = 1'b0;
            end else begin
                lat--;
            end
        end else begin
            rv = ($urandom_range(99) < p_spur);
            if (imem_req && imem_ready) begin
                check("fetch_addr", imem_addr, exp_fetch);
                out_addr    = imem_addr;
                outstanding = 1'b1;
                out_dead    = br;
                lat         = $urandom_range(max_lat);
                exp_fetch   = exp_fetch + 32'd4;
            end
        end
        imem_rvalid = rv;
        if (br) begin
            sb_q.delete();
            exp_fetch = tgt & 32'hFFFF_FFFC;
            if (outstanding) out_dead = 1'b1;
        end
        cyc_stall  = stall;
        cyc_branch = br;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            step(1'b0, 32'h0, 1'b0);
        end
    endtask

    task automatic check_reset_outputs();
        check("reset_ir", if_id_IR, NOP);
        check("reset_pc", if_id_PC, 32'h0);
        check("reset_valid", {31'b0, if_id_valid_inst}, 32'h0);
        check("reset_req", {31'b0, imem_req}, 32'h1);
        check("reset_addr", imem_addr, RST_PC);
    endtask

    // Monitor
    logic [31:0] prev_ir, prev_pc;
    logic        prev_v;
    exp_t        mon_e;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (cyc_branch) begin
                check("redirect_valid", {31'b0, if_id_valid_inst}, 32'h0);
                check("redirect_ir", if_id_IR, NOP);
            end else if (cyc_stall) begin
                check("hold_ir", if_id_IR, prev_ir);
                check("hold_pc", if_id_PC, prev_pc);
                check("hold_valid", {31'b0, if_id_valid_inst}, {31'b0, prev_v});
            end else if (if_id_valid_inst) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got pc %h expected no delivery", if_id_PC);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("deliver_pc", if_id_PC, mon_e.pc);
                    check("deliver_ir", if_id_IR, mon_e.ir);
                end
            end else begin
                check("bubble_ir", if_id_IR, NOP);
            end
        end
        prev_ir = if_id_IR;
        prev_pc = if_id_PC;
        prev_v  = if_id_valid_inst;
    end

    initial begin
        bit found;
        model_reset();
        set_knobs(100, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs();

        // Zero-wait memory, then stalls, then wrap through 0xFFFF_FFFC
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0);
        run(12);
        set_knobs(100, 50, 0, 0, 0);
        run(40);
        set_knobs(100, 0, 0, 0, 0);
        @(negedge clk);
        step(1'b1, 32'hFFFF_FFF8, 1'b0);
        run(10);

        // Redirect together with stall
        @(negedge clk);
        step(1'b1, 32'h0000_0100, 1'b1);
        run(6);

        set_knobs(70, 30, 8, 10, 3);
        run(3000);

        // Reset while a fetch is in flight
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (outstanding) found = 1'b1;
            else step(1'b0, 32'h0, 1'b0);
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_outstanding: got none expected a fetch in flight");
        end
        take_branch = 1'b0;
        stall       = 1'b0;
        imem_rvalid = 1'b0;
        imem_ready  = 1'b0;
        rst         = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0);
        run(1000);

        // Drain: no new requests, let the last response reach IF/ID
        set_knobs(0, 0, 0, 0, 3);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            step(1'b0, 32'h0, 1'b0);
            if (!outstanding && sb_q.size() == 0) break;
        end
        @(negedge clk);
        check("drain_empty", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
